armleocpu_multiplier_iter: RTL and testbench
============================================

# armleocpu_multiplier_iter

Parametrised iterative multiplier for the ArmleoCPU execute stage, successor to the single-cycle 32x32 multiplier. Produces the full 2*WIDTH-bit product over WIDTH/STEP cycles, trading latency for area. Supports unsigned, signed and signed-by-unsigned operand modes for RV32M MUL/MULH/MULHSU/MULHU, with an abort input for pipeline flushes.

## Interface
- WIDTH, 32, operand width; must be a multiple of STEP and at least 4.
- STEP, 2, product bits retired per cycle (1, 2 or 4); N = WIDTH/STEP iterations.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-high.
- valid  input  1  request; sampled only in IDLE.
- op  input  2  mode: 00 unsigned x unsigned, 01 signed x signed, 10 signed(factor0) x unsigned(factor1), 11 reserved (treated as 00).
- factor0  input  WIDTH  multiplicand.
- factor1  input  WIDTH  multiplier.
- kill  input  1  synchronous abort of an in-flight operation.
- ready  output  1  one-cycle completion pulse; result valid while high.
- result  output  2*WIDTH  full product, registered.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset: state=IDLE, ready=0, result=0, counter=0, internal accumulators=0.
- IDLE: valid=1 and kill=0 at an edge -> latch |factor0|, |factor1| per op, latch negate flag (sign0 XOR sign1 for signed operands), clear accumulator, counter=0 -> BUSY. kill=1 blocks acceptance.
- BUSY: each edge adds STEP partial products (multiplicand x next STEP multiplier bits, shifted) into the 2*WIDTH accumulator, counter+1. On the edge where counter==N-1: write result (two's-complement negated if negate flag), -> DONE.
- BUSY with kill=1: -> IDLE at that edge, no ready, result unchanged.
- DONE: ready=1 for exactly one cycle; -> IDLE unconditionally. kill in DONE ignored.
- result holds its value from DONE until the next completed operation (not cleared by accept or kill).
- Operands and op are captured at accept; requester may change them afterwards.
- Signed mode: most-negative operand (e.g. 0x8000_0000) absolute value computed in WIDTH+1 bits; no overflow, full product exact.
- All arithmetic modulo 2^(2*WIDTH).

## Timing
- Accept edge = edge T. ready high during cycle after edge T+N (latency N cycles; 16 for defaults).
- Earliest next accept at edge T+N+2 (valid held high across DONE is ignored in DONE, accepted in following IDLE); throughput one op per N+2 cycles.
- ready is a pure state decode of DONE; no combinational path from inputs to outputs.
- rst_n asserted at any time, including mid-BUSY or during DONE: outputs immediately return to reset values, in-flight operation discarded.
- valid low during BUSY has no effect; operation runs to completion unless killed.

## Configuration
- ARMLEOCPU_MULT_SIGNED_EN defined: op decoded as above, sign/negate logic present.
- Not defined: op port present but ignored; every operation unsigned x unsigned; no absolute-value or negate logic synthesised.

## Test plan
- UU 64 x 53, defaults -> ready exactly 16 cycles after accept, result=0xD40; ready low in every other cycle.
- UU 0xFFFF_FFFF x 0xFFFF_FFFF -> result=0xFFFF_FFFE_0000_0001; repeat with STEP=1 (ready after 32) and STEP=4 (after 8), same value.
- SS 0xFFFF_FFFF x 0xFFFF_FFFF -> 0x1; SS 0x8000_0000 x 0x8000_0000 -> 0x4000_0000_0000_0000; SU 0xFFFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE (without ARMLEOCPU_MULT_SIGNED_EN: SU case -> 0x1_FFFF_FFFE).
- valid held high continuously with 7 x 9 -> ready pulses at accept+16, next accept at accept+18, result=63 each time.
- kill asserted 5 cycles after accepting 3 x 4 -> no ready, result keeps prior value; next op 5 x 6 -> result=30.
- rst_n asserted mid-BUSY -> ready=0, result=0 immediately; after release, 2 x 3 -> result=6 after 16 cycles.

Source files
------------

// File: rtl/armleocpu_multiplier_iter_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
interface armleocpu_multiplier_iter_if #(
  parameter int WIDTH = 32
);
  logic                 valid;
  logic [1:0]           op;
  logic [WIDTH-1:0]     factor0;
  logic [WIDTH-1:0]     factor1;
  logic                 kill;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (output valid, op, factor0, factor1, kill, input ready, result);
  modport slave  (input valid, op, factor0, factor1, kill, output ready, result);
endinterface

// File: rtl/armleocpu_multiplier_iter.sv
// Iterative WIDTH x WIDTH multiplier retiring STEP multiplier bits per cycle.
// Signed modes are built only when ARMLEOCPU_MULT_SIGNED_EN is defined.
module armleocpu_multiplier_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  armleocpu_multiplier_iter_if.slave mul
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = WIDTH + STEP;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 accept, last;
  logic [WIDTH-1:0]     abs0, abs1;
  logic [PW-1:0]        pp;
  logic [2*WIDTH-1:0]   sum, fin;

  assign accept = (state_q == IDLE) && mul.valid && !mul.kill;
  assign last   = (cnt_q == CW'(N - 1));

`ifdef ARMLEOCPU_MULT_SIGNED_EN
  logic s0, s1, neg_q;

  // Magnitude of the most-negative operand is 2^(WIDTH-1), which still fits WIDTH unsigned bits.
  always_comb begin
    s0   = ((mul.op == 2'b01) || (mul.op == 2'b10)) && mul.factor0[WIDTH-1];
    s1   = (mul.op == 2'b01) && mul.factor1[WIDTH-1];
    abs0 = s0 ? -mul.factor0 : mul.factor0;
    abs1 = s1 ? -mul.factor1 : mul.factor1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)       neg_q <= 1'b0;
    else if (accept) neg_q <= s0 ^ s1;
  end

  assign fin = neg_q ? -sum : sum;
`else
  logic [1:0] unused_op;
  assign unused_op = mul.op;
  assign abs0      = mul.factor0;
  assign abs1      = mul.factor1;
  assign fin       = sum;
`endif

  // STEP partial products of the low multiplier bits, placed at the current digit position.
  always_comb begin
    pp = '0;
    for (int j = 0; j < STEP; j++)
      if (mplier_q[j]) pp = pp + (PW'(mcand_q) << j);
    sum = acc_q + ((2*WIDTH)'(pp) << (cnt_q * STEP));
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (accept) begin
      cnt_d    = '0;
      mcand_d  = abs0;
      mplier_d = abs1;
      acc_d    = '0;
    end else if ((state_q == BUSY) && !mul.kill) begin
      acc_d    = sum;
      mplier_d = mplier_q >> STEP;
      cnt_d    = last ? '0 : cnt_q + CW'(1);
      if (last) result_d = fin;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (mul.kill) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul.ready = (state_q == DONE);
  end

  assign mul.result = result_q;
endmodule

// File: tb/tb_armleocpu_multiplier_iter.sv
// Directed bench: three multipliers (STEP 2/1/4) share one request stream.
module tb_armleocpu_multiplier_iter;
  logic clk = 1'b0;
  logic rst_n;
  logic valid, kill;
  logic [1:0] op;
  logic [31:0] f0, f1;

  always #5 clk = ~clk;

  armleocpu_multiplier_iter_if #(.WIDTH(32)) if2 ();
  armleocpu_multiplier_iter_if #(.WIDTH(32)) if1 ();
  armleocpu_multiplier_iter_if #(.WIDTH(32)) if4 ();

  assign if2.valid = valid;  assign if2.op = op;  assign if2.factor0 = f0;  assign if2.factor1 = f1;  assign if2.kill = kill;
  assign if1.valid = valid;  assign if1.op = op;  assign if1.factor0 = f0;  assign if1.factor1 = f1;  assign if1.kill = kill;
  assign if4.valid = valid;  assign if4.op = op;  assign if4.factor0 = f0;  assign if4.factor1 = f1;  assign if4.kill = kill;

  armleocpu_multiplier_iter #(.WIDTH(32), .STEP(2)) u_s2 (.clk(clk), .rst_n(rst_n), .mul(if2));
  armleocpu_multiplier_iter #(.WIDTH(32), .STEP(1)) u_s1 (.clk(clk), .rst_n(rst_n), .mul(if1));
  armleocpu_multiplier_iter #(.WIDTH(32), .STEP(4)) u_s4 (.clk(clk), .rst_n(rst_n), .mul(if4));

  logic [2:0]  rdy;
  logic [63:0] rs [3];
  assign rdy   = {if4.ready, if1.ready, if2.ready};
  assign rs[0] = if2.result;
  assign rs[1] = if1.result;
  assign rs[2] = if4.result;

`ifdef ARMLEOCPU_MULT_SIGNED_EN
  localparam logic [63:0] EXP_SS_M1 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] EXP_SU    = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] EXP_SS_M3 = 64'hFFFF_FFFF_FFFF_FFF1;
`else
  localparam logic [63:0] EXP_SS_M1 = 64'hFFFF_FFFE_0000_0001;
  localparam logic [63:0] EXP_SU    = 64'h0000_0001_FFFF_FFFE;
  localparam logic [63:0] EXP_SS_M3 = 64'h0000_0004_FFFF_FFF1;
`endif

  int tests = 0;
  int fails = 0;
  int lat [3];
  int np  [3];
  logic [63:0] res [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one request, scramble the inputs, then watch 40 cycles; j=0 is the cycle after accept.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; f0 = a; f1 = b; valid = 1'b1;
    tick;
    valid = 1'b0; op = 2'b01; f0 = 32'hDEAD_BEEF; f1 = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; np[i] = 0; res[i] = '0; end
    for (int j = 0; j <= 40; j++) begin
      if (j > 0) tick;
      for (int i = 0; i < 3; i++)
        if (rdy[i] === 1'b1) begin
          np[i]++;
          if (lat[i] < 0) begin lat[i] = j; res[i] = rs[i]; end
        end
    end
  endtask

  initial begin
    int p [2];
    int n;
    logic [63:0] pr [2];

    rst_n = 1'b1; valid = 1'b0; kill = 1'b0; op = 2'b00; f0 = '0; f1 = '0;
    tick; tick;
    chk("reset_ready", 64'(rdy), 64'd0);
    chk("reset_result", rs[0], 64'd0);
    rst_n = 1'b0;
    tick;

    run_op(2'b00, 32'd64, 32'd53);
    chk("uu_small_res", res[0], 64'hD40);
    chk("uu_small_lat", 64'(lat[0]), 64'd16);
    chk("uu_small_pulses", 64'(np[0]), 64'd1);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("uu_max_res_s2", res[0], 64'hFFFF_FFFE_0000_0001);
    chk("uu_max_lat_s2", 64'(lat[0]), 64'd16);
    chk("uu_max_res_s1", res[1], 64'hFFFF_FFFE_0000_0001);
    chk("uu_max_lat_s1", 64'(lat[1]), 64'd32);
    chk("uu_max_res_s4", res[2], 64'hFFFF_FFFE_0000_0001);
    chk("uu_max_lat_s4", 64'(lat[2]), 64'd8);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ss_m1_res", res[0], EXP_SS_M1);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000);
    chk("ss_minneg_res", res[0], 64'h4000_0000_0000_0000);
    chk("ss_minneg_res_s1", res[1], 64'h4000_0000_0000_0000);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2);
    chk("su_res", res[0], EXP_SU);
    chk("su_res_s4", res[2], EXP_SU);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    chk("ss_m3_res", res[0], EXP_SS_M3);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("reserved_op_res", res[0], 64'hFFFF_FFFE_0000_0001);

    // valid held high: second accept lands 18 edges after the first
    op = 2'b00; f0 = 32'd7; f1 = 32'd9; valid = 1'b1;
    tick;
    n = 0; p[0] = -1; p[1] = -1; pr[0] = '0; pr[1] = '0;
    for (int j = 0; j <= 40; j++) begin
      if (j > 0) tick;
      if (rdy[0] === 1'b1) begin
        if (n < 2) begin p[n] = j; pr[n] = rs[0]; end
        n++;
      end
      if (j == 34) valid = 1'b0;
    end
    chk("held_pulses", 64'(n), 64'd2);
    chk("held_first_at", 64'(p[0]), 64'd16);
    chk("held_second_at", 64'(p[1]), 64'd34);
    chk("held_res1", pr[0], 64'd63);
    chk("held_res2", pr[1], 64'd63);
    repeat (70) tick;

    // kill 5 edges after accept
    op = 2'b00; f0 = 32'd3; f1 = 32'd4; valid = 1'b1;
    tick;
    valid = 1'b0;
    repeat (4) tick;
    kill = 1'b1;
    tick;
    kill = 1'b0;
    n = 0;
    for (int j = 0; j < 40; j++) begin
      tick;
      if (rdy[0] === 1'b1) n++;
    end
    chk("kill_no_ready", 64'(n), 64'd0);
    chk("kill_res_held", rs[0], 64'd63);
    run_op(2'b00, 32'd5, 32'd6);
    chk("after_kill_res", res[0], 64'd30);
    chk("after_kill_lat", 64'(lat[0]), 64'd16);

    // asynchronous reset mid-BUSY
    op = 2'b00; f0 = 32'd9; f1 = 32'd9; valid = 1'b1;
    tick;
    valid = 1'b0;
    repeat (5) tick;
    #2 rst_n = 1'b1;
    #1;
    chk("midreset_ready", 64'(rdy), 64'd0);
    chk("midreset_result", rs[0], 64'd0);
    chk("midreset_result_s1", rs[1], 64'd0);
    tick; tick;
    rst_n = 1'b0;
    tick;
    run_op(2'b00, 32'd2, 32'd3);
    chk("after_reset_res", res[0], 64'd6);
    chk("after_reset_lat", 64'(lat[0]), 64'd16);
    chk("after_reset_pulses", 64'(np[0]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
